// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle ARM-subset control unit.
// Optional BL support is selected with MCCTRL_BL_EN.
package mc_ctrl_pkg;

    // FSM states; encodings are fixed so the debug port is stable across builds
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXECR    = 4'd2,
        EXECI    = 4'd3,
        ALUWB    = 4'd4,
        MEMADR   = 4'd5,
        MEMREAD  = 4'd6,
        MEMWB    = 4'd7,
        MEMWRITE = 4'd8,
        BRANCH   = 4'd9,
        BXEX     = 4'd10
`ifdef MCCTRL_BL_EN
        ,
        BLINK    = 4'd11,
        BADJ     = 4'd12
`endif
    } state_e;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_CMP = 4'b1010;

    // ALU operand B select
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] SRCB_ZERO = 2'b11;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // Immediate extension select
    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    // Condition codes that can ever evaluate true
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Funct pattern identifying BX within the data-processing op class
    localparam logic [5:0] BX_FUNCT = 6'b010010;

    function automatic logic is_bx_instr(input logic [1:0] op, input logic [5:0] funct);
        return (op == 2'b00) && (funct == BX_FUNCT);
    endfunction

endpackage

// File: rtl/multicycle_controller_cond_check.sv
// Condition evaluation: only EQ, NE and AL are supported; all other codes never execute.
module cond_check
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       z,
    output logic       cond_ex
);

    // Decode the condition field against the registered zero flag
    always_comb begin
        cond_ex = 1'b0;
        unique case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle ARM-subset core.
// Outputs decode combinationally from the registered state and instruction fields.
// Define MCCTRL_BL_EN to give BL its link-register path (BLINK/BADJ); otherwise BL runs as B.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         Cond,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    input  logic               Z,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic               Z_enable,
    output logic               BLenable,
    output logic               BXenable,
    output logic [1:0]         RegSrc,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [3:0]         ALUControl,
    output logic [STATE_W-1:0] state
);

    state_e state_q, state_d;
    logic   cond_ex;
    logic   is_bx;
    logic   rd_is_pc;

    cond_check u_cond_check (
        .cond    (Cond),
        .z       (Z),
        .cond_ex (cond_ex)
    );

    assign is_bx    = is_bx_instr(Op, Funct);
    assign rd_is_pc = (Rd == 4'd15);

    // Per-state control decode and next-state selection; write strobes gated off during reset
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        Z_enable   = 1'b0;
        BLenable   = 1'b0;
        BXenable   = 1'b0;
        RegSrc     = 2'b00;
        ImmSrc     = IMM_8;
        ALUSrcB    = SRCB_RD2;
        ResultSrc  = RES_ALUOUT;
        ALUControl = 4'b0000;
        state_d    = state_q;

        unique case (state_q)
            FETCH: begin
                IRWrite    = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ALUControl = ALU_ADD;
                ResultSrc  = RES_ALURES;
                PCWrite    = 1'b1;
                state_d    = DECODE;
            end
            DECODE: begin
                // PC+4 here reads back as R15 (instruction address + 8)
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ALUControl = ALU_ADD;
                ResultSrc  = RES_ALURES;
                RegSrc[0]  = (Op == 2'b10);
                RegSrc[1]  = (Op == 2'b01) && !Funct[0];
                BXenable   = is_bx;
                if (!cond_ex || Op == 2'b11) begin
                    state_d = FETCH;
                end else begin
                    unique case (Op)
                        2'b00: begin
                            if (is_bx)         state_d = BXEX;
                            else if (Funct[5]) state_d = EXECI;
                            else               state_d = EXECR;
                        end
                        2'b01: state_d = MEMADR;
`ifdef MCCTRL_BL_EN
                        2'b10: state_d = Funct[4] ? BLINK : BRANCH;
`else
                        2'b10: state_d = BRANCH;
`endif
                        default: state_d = FETCH;
                    endcase
                end
            end
            EXECR, EXECI: begin
                ALUControl = Funct[4:1];
                Z_enable   = Funct[0];
                if (state_q == EXECI) begin
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = IMM_8;
                end else begin
                    ALUSrcB = SRCB_RD2;
                end
                // CMP only updates flags, so there is nothing to write back
                state_d = (Funct[4:1] == ALU_CMP) ? FETCH : ALUWB;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
                PCWrite   = rd_is_pc;
                state_d   = FETCH;
            end
            MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_12;
                ALUControl = Funct[3] ? ALU_ADD : ALU_SUB;
                state_d    = Funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUT;
                state_d   = MEMWB;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                PCWrite   = rd_is_pc;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUT;
                MemWrite  = 1'b1;
                RegSrc    = 2'b10;
                state_d   = FETCH;
            end
`ifdef MCCTRL_BL_EN
            BLINK: begin
                // R14 <- PC (already instruction address + 4) + 0
                RegSrc     = 2'b01;
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_ZERO;
                ALUControl = ALU_ADD;
                ResultSrc  = RES_ALURES;
                RegWrite   = 1'b1;
                BLenable   = 1'b1;
                state_d    = BADJ;
            end
            BADJ: begin
                // Rebuild the branch base in A before the offset add
                RegSrc     = 2'b01;
                ALUSrcB    = SRCB_FOUR;
                ALUControl = ALU_ADD;
                ResultSrc  = RES_ALURES;
                state_d    = BRANCH;
            end
`endif
            BRANCH: begin
                RegSrc     = 2'b01;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_24;
                ALUControl = ALU_ADD;
                ResultSrc  = RES_ALURES;
                PCWrite    = 1'b1;
                state_d    = FETCH;
            end
            BXEX: begin
                BXenable   = 1'b1;
                ALUSrcB    = SRCB_ZERO;
                ALUControl = ALU_ADD;
                ResultSrc  = RES_ALURES;
                PCWrite    = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase

        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            Z_enable = 1'b0;
        end
    end

    // State register; reset abandons any in-flight instruction
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction's per-cycle
// strobes are summarised and compared with an instruction-level profile.
module tb_multicycle_controller;
    import mc_ctrl_pkg::*;

`ifdef MCCTRL_BL_EN
    localparam bit BL_EN = 1'b1;
`else
    localparam bit BL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond, Rd, ALUControl, state;
    logic [1:0] Op, RegSrc, ImmSrc, ALUSrcB, ResultSrc;
    logic [5:0] Funct;
    logic       Z;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic       Z_enable, BLenable, BXenable;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd), .Z(Z),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .Z_enable(Z_enable), .BLenable(BLenable),
        .BXenable(BXenable), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ALUControl(ALUControl), .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Instruction-level profile: cycle count and how many cycles each strobe is high
    typedef struct packed {
        int         cycles;
        int         irw;
        int         pcw;
        int         rw;
        int         mw;
        int         zen;
        int         bl;
        int         bx;
        int         adr;
        logic [3:0] alu3;
        logic [1:0] rsrc;
    } prof_t;

    function automatic prof_t model(input logic [3:0] c, input logic [1:0] o,
                                    input logic [5:0] f, input logic [3:0] r, input logic z);
        prof_t p;
        bit    ok, bx;
        int    pc_wb;
        p        = '0;
        p.cycles = 2;
        p.irw    = 1;
        p.pcw    = 1;
        p.alu3   = 4'b0100;
        ok    = (c == 4'd0 && z) || (c == 4'd1 && !z) || (c == 4'd14);
        bx    = (o == 2'd0) && (f == 6'b010010);
        pc_wb = (r == 4'd15) ? 1 : 0;
        if (bx) p.bx = 1;
        if (!ok || o == 2'd3) return p;
        if (bx) begin
            p.cycles = 3; p.pcw = 2; p.bx = 2;
        end else if (o == 2'd0) begin
            p.zen  = int'(f[0]);
            p.alu3 = f[4:1];
            if (f[4:1] == 4'b1010) p.cycles = 3;
            else begin p.cycles = 4; p.rw = 1; p.pcw = 1 + pc_wb; end
        end else if (o == 2'd1) begin
            p.alu3 = f[3] ? 4'b0100 : 4'b0010;
            p.adr  = 1;
            if (f[0]) begin p.cycles = 5; p.rw = 1; p.rsrc = 2'b01; p.pcw = 1 + pc_wb; end
            else      begin p.cycles = 4; p.mw = 1; end
        end else begin
            if (BL_EN && f[4]) begin
                p.cycles = 5; p.rw = 1; p.bl = 1; p.rsrc = 2'b10; p.pcw = 2;
            end else begin
                p.cycles = 3; p.pcw = 2;
            end
        end
        return p;
    endfunction

    // Called just after a falling edge while the DUT sits in FETCH
    task automatic run_instr(input string nm, input logic [31:0] instr, input logic z);
        prof_t e, g;
        int    cyc;
        bit    done;
        Cond  = instr[31:28];
        Op    = instr[27:26];
        Funct = instr[25:20];
        Rd    = instr[15:12];
        Z     = z;
        e     = model(Cond, Op, Funct, Rd, z);
        g     = '0;
        cyc   = 0;
        done  = 1'b0;
        while (!done && cyc < 12) begin
            #1;
            if (cyc > 0 && IRWrite) begin
                done = 1'b1;
            end else begin
                g.irw += int'(IRWrite);
                g.pcw += int'(PCWrite);
                g.rw  += int'(RegWrite);
                g.mw  += int'(MemWrite);
                g.zen += int'(Z_enable);
                g.bl  += int'(BLenable);
                g.bx  += int'(BXenable);
                g.adr += int'(AdrSrc);
                if (cyc == 2) g.alu3 = ALUControl;
                if (RegWrite) g.rsrc = ResultSrc;
                cyc++;
                @(negedge clk);
            end
        end
        if (!done) chk({nm, ":no_refetch"}, 32'd0, 32'd1);
        chk({nm, ":cycles"}, cyc, e.cycles);
        chk({nm, ":irwrite"}, g.irw, e.irw);
        chk({nm, ":pcwrite"}, g.pcw, e.pcw);
        chk({nm, ":regwrite"}, g.rw, e.rw);
        chk({nm, ":memwrite"}, g.mw, e.mw);
        chk({nm, ":z_enable"}, g.zen, e.zen);
        chk({nm, ":blenable"}, g.bl, e.bl);
        chk({nm, ":bxenable"}, g.bx, e.bx);
        chk({nm, ":adrsrc"}, g.adr, e.adr);
        if (e.cycles > 2) chk({nm, ":alu_op"}, {28'd0, g.alu3}, {28'd0, e.alu3});
        if (e.rw > 0) chk({nm, ":wb_src"}, {30'd0, g.rsrc}, {30'd0, e.rsrc});
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom();
        k = $urandom_range(0, 3);
        if (k == 0)      w[31:28] = 4'd0;
        else if (k == 1) w[31:28] = 4'd1;
        else if (k == 2) w[31:28] = 4'd14;
        if ($urandom_range(0, 7) == 0) begin
            w[27:26] = 2'b00;
            w[25:20] = 6'b010010;
        end
        if ($urandom_range(0, 3) == 0) w[15:12] = 4'd15;
        return w;
    endfunction

    initial begin
        reset = 1'b1;
        Cond  = 4'd0; Op = 2'd0; Funct = 6'd0; Rd = 4'd0; Z = 1'b0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_state", {28'd0, state}, {28'd0, FETCH});
            chk("rst_wen", {27'd0, PCWrite, IRWrite, RegWrite, MemWrite, Z_enable}, 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("post_rst_irwrite", {31'd0, IRWrite}, 32'd1);
        chk("post_rst_state", {28'd0, state}, {28'd0, FETCH});

        // Directed instructions
        run_instr("add", 32'hE0821003, 1'b0);
        run_instr("subs", 32'hE0521003, 1'b0);
        run_instr("beq_nt", 32'h0A000002, 1'b0);
        run_instr("beq_t", 32'h0A000002, 1'b1);
        run_instr("ldr", 32'hE5910004, 1'b0);
        run_instr("str", 32'hE5810004, 1'b0);
        run_instr("bl", 32'hEB000001, 1'b0);
        run_instr("bx", 32'hE12FFF1E, 1'b0);
        run_instr("cmp", 32'hE3500000, 1'b1);
        run_instr("ldr_pc", 32'hE591F004, 1'b0);
        run_instr("ne_skip", 32'h10821003, 1'b1);

        // Reset in the middle of an LDR
        Cond = 4'd14; Op = 2'b01; Funct = 6'b011001; Rd = 4'd0; Z = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_state", {28'd0, state}, {28'd0, MEMADR});
        reset = 1'b1;
        #1;
        chk("mid_rst_wen0", {27'd0, PCWrite, IRWrite, RegWrite, MemWrite, Z_enable}, 32'd0);
        @(negedge clk);
        #1;
        chk("mid_rst_state", {28'd0, state}, {28'd0, FETCH});
        chk("mid_rst_wen1", {27'd0, PCWrite, IRWrite, RegWrite, MemWrite, Z_enable}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rel_irwrite", {31'd0, IRWrite}, 32'd1);

        // Randomized instruction stream
        for (int i = 0; i < 150; i++) begin
            run_instr($sformatf("rnd%0d", i), rand_instr(), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
